// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: WIDTH-bit words in over valid/ready, MSB-first out.
// A one-word holding buffer lets consecutive frames run with no idle bit between them.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             frame_active,
  output logic             frame_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] hold_reg;
  logic [CW-1:0]    bit_cnt;
  logic             hold_full;
  logic             accept;
  logic             last;

  assign in_ready     = !hold_full;
  assign accept       = in_valid & in_ready;
  assign last         = (state == SHIFT) && (bit_cnt == LAST_CNT);
  assign serial_out   = (state == SHIFT) ? shift_reg[WIDTH-1] : 1'b0;
  assign frame_active = (state == SHIFT);
  assign frame_done   = last;

  // On the last bit a held word takes precedence over a fresh accept; the hold
  // buffer being full also forces in_ready low, so both can never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= in_data;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
            if (accept) begin
              hold_reg  <= in_data;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            shift_reg <= hold_reg;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
          end else if (accept) begin
            shift_reg <= in_data;
            bit_cnt   <= '0;
          end else begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed and loopback checks for piso_serializer (WIDTH=4), sampling 1 time unit after each rising edge.
module tb_piso_serializer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             serial_out;
  logic             frame_active;
  logic             frame_done;

  int checks;
  int errors;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .serial_out   (serial_out),
    .frame_active (frame_active),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hF;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({serial_out, frame_active, frame_done, in_ready} !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got out/act/done/rdy=%b%b%b%b want 0001",
                 i, serial_out, frame_active, frame_done, in_ready);
      end
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (frame_active !== 1'b0 || serial_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_no_tx cycle %0d: got act=%b out=%b want 0 0",
                 i, frame_active, serial_out);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [3:0] word;
    word     = 4'b1011;
    in_data  = word;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (serial_out !== word[3-i] || frame_active !== 1'b1 || frame_done !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL single_bit%0d: got out=%b act=%b done=%b want out=%b act=1 done=%b",
                 i, serial_out, frame_active, frame_done, word[3-i], (i == 3));
      end
      step();
    end
    checks++;
    if (serial_out !== 1'b0 || frame_active !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: got out=%b act=%b done=%b want 0 0 0",
               serial_out, frame_active, frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream;
    logic       exp_rdy;
    stream   = 8'hA5;
    in_data  = 4'hA;
    in_valid = 1'b1;
    step();
    in_data  = 4'h5;
    for (int i = 0; i < 8; i++) begin
      exp_rdy = !(i >= 1 && i <= 3);
      checks++;
      if (serial_out !== stream[7-i] || frame_active !== 1'b1 ||
          frame_done !== (i == 3 || i == 7) || in_ready !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL b2b_bit%0d: got out=%b act=%b done=%b rdy=%b want out=%b act=1 done=%b rdy=%b",
                 i, serial_out, frame_active, frame_done, in_ready, stream[7-i],
                 (i == 3 || i == 7), exp_rdy);
      end
      step();
      if (i == 0) in_valid = 1'b0;
    end
    checks++;
    if (frame_active !== 1'b0 || serial_out !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got act=%b out=%b rdy=%b want 0 0 1",
               frame_active, serial_out, in_ready);
    end
  endtask

  task automatic test_hold_mid_frame();
    logic [7:0] stream;
    logic       exp_rdy;
    int         done_count;
    stream     = 8'h3C;
    done_count = 0;
    in_data    = 4'h3;
    in_valid   = 1'b1;
    step();
    in_valid   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        in_data  = 4'hC;
        in_valid = 1'b1;
      end
      if (i == 2) in_valid = 1'b0;
      exp_rdy = !(i == 2 || i == 3);
      if (frame_done === 1'b1) done_count++;
      checks++;
      if (serial_out !== stream[7-i] || frame_active !== 1'b1 || in_ready !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL hold_bit%0d: got out=%b act=%b rdy=%b want out=%b act=1 rdy=%b",
                 i, serial_out, frame_active, in_ready, stream[7-i], exp_rdy);
      end
      step();
    end
    checks++;
    if (done_count != 2 || frame_active !== 1'b0 || serial_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_end: got done_pulses=%0d act=%b out=%b want 2 0 0",
               done_count, frame_active, serial_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    in_data  = 4'hF;
    in_valid = 1'b1;
    step();
    in_data  = 4'h9;
    step();
    in_valid = 1'b0;
    checks++;
    if (serial_out !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_pre: got out=%b rdy=%b want 1 0", serial_out, in_ready);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({serial_out, frame_active, frame_done, in_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midrst_outputs: got out/act/done/rdy=%b%b%b%b want 0001",
               serial_out, frame_active, frame_done, in_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (serial_out !== 1'b0 || frame_active !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_quiet cycle %0d: got out=%b act=%b want 0 0",
                 i, serial_out, frame_active);
      end
    end
  endtask

  task automatic test_loopback();
    logic [3:0] exp_q[$];
    logic [3:0] rx;
    logic [3:0] expw;
    int         sent;
    int         received;
    int         cycles;
    sent     = 0;
    received = 0;
    cycles   = 0;
    rx       = '0;
    in_valid = 1'b0;
    while (received < 50 && cycles < 3000) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
        step();
        in_valid = 1'b0;
      end else begin
        step();
      end
      cycles++;
      if (frame_active === 1'b1) begin
        rx = {rx[2:0], serial_out};
        if (frame_done === 1'b1) begin
          expw = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
          received++;
          checks++;
          if (rx !== expw) begin
            errors++;
            $display("[TB] FAIL loopback_word%0d: got %h want %h", received, rx, expw);
          end
        end
      end
      if (!in_valid && sent < 50 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = 4'($urandom);
      end
    end
    checks++;
    if (received != 50) begin
      errors++;
      $display("[TB] FAIL loopback_timeout: got %0d words want 50", received);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_hold_mid_frame();
    test_reset_mid_frame();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
